// File: rtl/conv_vector_feeder.sv
// Serial-nibble to 32-lane vector feeder for the convolution engine: builds one
// weight vector and NUM_WIN IFM vectors, strobes them out, and forwards the results.
//
// state    | meaning
// S_IDLE   | waiting for start
// S_LOAD_W | collecting weight nibbles into the shadow register
// S_FIRE_W | weight_bus updated, weight_valid high
// S_LOAD_I | collecting IFM nibbles into the shadow register
// S_FIRE_I | ifm_bus updated, in_valid high
// S_DRAIN  | all vectors sent, waiting for the remaining results
module conv_vector_feeder #(
  parameter int LANES   = 32,
  parameter int DW      = 4,
  parameter int NUM_WIN = 16,
  parameter int OW      = 13
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                start,
  output logic                busy,
  input  logic                s_valid,
  output logic                s_ready,
  input  logic [DW-1:0]       s_data,
  output logic [LANES*DW-1:0] weight_bus,
  output logic [LANES*DW-1:0] ifm_bus,
  output logic                weight_valid,
  output logic                in_valid,
  input  logic                out_valid,
  input  logic [OW-1:0]       Out_OFM,
  output logic                r_valid,
  output logic [OW-1:0]       r_data,
  output logic                done,
  output logic                err
);

  localparam int LW = $clog2(LANES);
  localparam int CW = $clog2(NUM_WIN + 1);
  localparam logic [LW-1:0] LAST_LANE = LW'(LANES - 1);
  localparam logic [CW-1:0] WIN_MAX   = CW'(NUM_WIN);

  typedef enum logic [2:0] {
    S_IDLE, S_LOAD_W, S_FIRE_W, S_LOAD_I, S_FIRE_I, S_DRAIN
  } state_t;

  state_t               r_state, w_next;
  logic [LW-1:0]        r_lane;
  logic [CW-1:0]        r_sent, r_res;
  logic [LANES*DW-1:0]  r_shadow, w_shadow_nxt;
  logic [LANES*DW-1:0]  r_weight_bus, r_ifm_bus;
  logic                 r_weight_valid, r_in_valid, r_rvalid, r_done, r_err;
  logic [OW-1:0]        r_rdata;
  logic                 w_accept, w_start, w_res_ok, w_spurious, w_last;
  logic                 w_fire_w, w_fire_i;

  assign busy         = (r_state != S_IDLE);
  assign s_ready      = (r_state == S_LOAD_W) || (r_state == S_LOAD_I);
  assign weight_bus   = r_weight_bus;
  assign ifm_bus      = r_ifm_bus;
  assign weight_valid = r_weight_valid;
  assign in_valid     = r_in_valid;
  assign r_valid      = r_rvalid;
  assign r_data       = r_rdata;
  assign done         = r_done;
  assign err          = r_err;

  assign w_accept   = s_valid && s_ready;
  assign w_last     = w_accept && (r_lane == LAST_LANE);
  assign w_start    = start && (r_state == S_IDLE);
  // A result is only legitimate if some fired vector has not been answered yet.
  assign w_res_ok   = out_valid && busy && (r_res != r_sent);
  assign w_spurious = out_valid && !w_res_ok;
  assign w_fire_w   = (r_state == S_LOAD_W) && w_last;
  assign w_fire_i   = (r_state == S_LOAD_I) && w_last;

  always_comb begin
    w_shadow_nxt = r_shadow;
    if (w_accept) w_shadow_nxt[r_lane*DW +: DW] = s_data;
  end

  always_comb begin
    w_next = r_state;
    unique case (r_state)
      S_IDLE:   if (w_start) w_next = S_LOAD_W;
      S_LOAD_W: if (w_last) w_next = S_FIRE_W;
      S_FIRE_W: w_next = S_LOAD_I;
      S_LOAD_I: if (w_last) w_next = S_FIRE_I;
      S_FIRE_I: w_next = (r_sent < WIN_MAX) ? S_LOAD_I : S_DRAIN;
      S_DRAIN:  if (r_res == WIN_MAX) w_next = S_IDLE;
      default:  w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state        <= S_IDLE;
      r_lane         <= '0;
      r_sent         <= '0;
      r_res          <= '0;
      r_shadow       <= '0;
      r_weight_bus   <= '0;
      r_ifm_bus      <= '0;
      r_weight_valid <= 1'b0;
      r_in_valid     <= 1'b0;
      r_rvalid       <= 1'b0;
      r_rdata        <= '0;
      r_done         <= 1'b0;
      r_err          <= 1'b0;
    end else begin
      r_state        <= w_next;
      r_shadow       <= w_shadow_nxt;
      r_weight_valid <= w_fire_w;
      r_in_valid     <= w_fire_i;
      r_rvalid       <= w_res_ok;
      r_done         <= (r_state == S_DRAIN) && (w_next == S_IDLE);
      if (w_accept) r_lane <= r_lane + 1'b1;
      // The bus takes the shadow including the nibble accepted on this edge.
      if (w_fire_w) r_weight_bus <= w_shadow_nxt;
      if (w_fire_i) begin
        r_ifm_bus <= w_shadow_nxt;
        r_sent    <= r_sent + 1'b1;
      end
      if (w_res_ok) begin
        r_res   <= r_res + 1'b1;
        r_rdata <= Out_OFM;
      end
      if (w_start) begin
        r_lane <= '0;
        r_sent <= '0;
        r_res  <= '0;
        r_err  <= 1'b0;
      end else if (w_spurious) begin
        r_err  <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_conv_vector_feeder.sv
// Scoreboard bench for conv_vector_feeder with a 4-cycle dot-product model of the
// convolution engine; NUM_WIN is reduced to 2 to keep jobs short.
module tb_conv_vector_feeder;

  localparam int NW = 2;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         start = 1'b0;
  logic         s_valid = 1'b0;
  logic [3:0]   s_data = '0;
  logic         out_valid = 1'b0;
  logic [12:0]  Out_OFM = '0;
  logic         busy, s_ready, weight_valid, in_valid, r_valid, done, err;
  logic [127:0] weight_bus, ifm_bus;
  logic [12:0]  r_data;

  int n_vec = 0;
  int n_err = 0;
  int cyc = 0;
  int inj_req = 0;
  int inj_seen = 0;
  logic prev_strobe = 1'b0;

  typedef struct {int due; logic [12:0] val;} pend_t;
  pend_t        pend[$];
  pend_t        pv;
  logic [127:0] exp_w[$];
  logic [127:0] exp_i[$];
  logic [12:0]  exp_r[$];

  conv_vector_feeder #(.LANES(32), .DW(4), .NUM_WIN(NW), .OW(13)) dut (
    .clk(clk), .rst(rst), .start(start), .busy(busy),
    .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data),
    .weight_bus(weight_bus), .ifm_bus(ifm_bus),
    .weight_valid(weight_valid), .in_valid(in_valid),
    .out_valid(out_valid), .Out_OFM(Out_OFM),
    .r_valid(r_valid), .r_data(r_data), .done(done), .err(err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] want);
    n_vec++;
    if (got !== want) begin
      n_err++;
      $display("FAIL %s: got %0h, wanted %0h", tag, got, want);
    end
  endtask

  function automatic logic [12:0] dot(input logic [127:0] a, input logic [127:0] b);
    int s = 0;
    for (int k = 0; k < 32; k++) s += int'(a[k*4 +: 4]) * int'(b[k*4 +: 4]);
    return 13'(s);
  endfunction

  // Convolution engine model: answers each in_valid 4 cycles later; can also inject a stray result.
  always @(posedge clk) begin
    #1;
    cyc++;
    out_valid = 1'b0;
    Out_OFM   = '0;
    if (inj_seen != inj_req) begin
      out_valid = 1'b1;
      Out_OFM   = 13'h0AB;
      inj_seen++;
    end else if (pend.size() != 0 && pend[0].due <= cyc) begin
      pv = pend.pop_front();
      out_valid = 1'b1;
      Out_OFM   = pv.val;
    end
  end

  always @(negedge clk) begin
    if (in_valid) pend.push_back('{due: cyc + 4, val: dot(weight_bus, ifm_bus)});
    if (weight_valid || in_valid) chk("strobe_gap", prev_strobe, 1'b0);
    prev_strobe = weight_valid || in_valid;
    if (weight_valid) begin
      chk("w_expected", exp_w.size() != 0, 1'b1);
      if (exp_w.size() != 0) chk("weight_bus", weight_bus, exp_w.pop_front());
    end
    if (in_valid) begin
      chk("i_expected", exp_i.size() != 0, 1'b1);
      if (exp_i.size() != 0) chk("ifm_bus", ifm_bus, exp_i.pop_front());
    end
    if (r_valid) begin
      chk("r_expected", exp_r.size() != 0, 1'b1);
      if (exp_r.size() != 0) chk("r_data", r_data, exp_r.pop_front());
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send_nib(input logic [3:0] d, input bit rnd);
    int   guard = 0;
    logic taken;
    forever begin
      if (rnd && $urandom_range(1, 0) == 0) begin
        s_valid = 1'b0;
        tick();
      end else begin
        s_valid = 1'b1;
        s_data  = d;
        taken   = s_ready;
        tick();
        if (taken) break;
      end
      guard++;
      if (guard > 200) begin
        chk("nib_timeout", guard, 0);
        break;
      end
    end
    s_valid = 1'b0;
  endtask

  task automatic send_vec(input logic [127:0] v, input bit rnd);
    for (int k = 0; k < 32; k++) send_nib(v[k*4 +: 4], rnd);
  endtask

  task automatic pulse_start(input int n);
    start = 1'b1;
    for (int k = 0; k < n; k++) tick();
    start = 1'b0;
  endtask

  task automatic check_zero(input string tag);
    chk({tag, "_busy"}, busy, 1'b0);
    chk({tag, "_s_ready"}, s_ready, 1'b0);
    chk({tag, "_wbus"}, weight_bus, 128'd0);
    chk({tag, "_ibus"}, ifm_bus, 128'd0);
    chk({tag, "_strobes"}, {weight_valid, in_valid, r_valid, done, err}, 5'd0);
    chk({tag, "_r_data"}, r_data, 13'd0);
  endtask

  task automatic run_job(input logic [127:0] w, input logic [127:0] i0,
                         input logic [127:0] i1, input bit rnd, input bit t6);
    bit got_done = 0;
    pulse_start(1);
    chk("busy_on", busy, 1'b1);
    chk("err_clr", err, 1'b0);
    send_vec(w, rnd);
    exp_w.push_back(w);
    send_vec(i0, rnd);
    exp_i.push_back(i0);
    exp_r.push_back(dot(w, i0));
    if (t6) pulse_start(2);
    send_vec(i1, rnd);
    exp_i.push_back(i1);
    exp_r.push_back(dot(w, i1));
    s_valid = t6;
    for (int c = 0; c < 300; c++) begin
      tick();
      if (t6) chk("drain_s_ready", s_ready, 1'b0);
      if (done) begin
        got_done = 1;
        break;
      end
    end
    chk("done_seen", got_done, 1'b1);
    chk("busy_at_done", busy, 1'b0);
    chk("results_left", exp_r.size(), 0);
    tick();
    chk("done_pulse", done, 1'b0);
    chk("busy_after", busy, 1'b0);
    if (t6) begin
      tick();
      chk("no_restart", {busy, s_ready}, 2'b00);
    end
    s_valid = 1'b0;
  endtask

  function automatic logic [127:0] fill(input logic [3:0] n);
    logic [127:0] v;
    for (int k = 0; k < 32; k++) v[k*4 +: 4] = n;
    return v;
  endfunction

  function automatic logic [127:0] rvec();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, got running, wanted finished");
    $fatal(1);
  end

  initial begin
    logic [127:0] wv;
    repeat (3) tick();
    check_zero("reset");
    rst = 1'b0;
    tick();

    // weights lane N = N mod 16
    for (int k = 0; k < 32; k++) wv[k*4 +: 4] = 4'((k + 1) % 16);
    run_job(wv, rvec(), rvec(), 0, 0);
    chk("lane1", weight_bus[3:0], 4'd1);
    chk("lane16", weight_bus[63:60], 4'd0);
    chk("lane32", weight_bus[127:124], 4'd0);

    // weights 2, IFM 3 then 1: results 192 and 64
    chk("dot_3", dot(fill(4'd2), fill(4'd3)), 13'd192);
    chk("dot_1", dot(fill(4'd2), fill(4'd1)), 13'd64);
    run_job(fill(4'd2), fill(4'd3), fill(4'd1), 0, 0);

    // same job with randomly throttled s_valid
    run_job(fill(4'd2), fill(4'd3), fill(4'd1), 1, 0);
    run_job(rvec(), rvec(), rvec(), 1, 0);

    // stray result in IDLE
    inj_req++;
    repeat (3) tick();
    chk("err_set", err, 1'b1);
    chk("err_busy", busy, 1'b0);

    // start clears err; abort with reset after 10 IFM nibbles
    pulse_start(1);
    chk("err_cleared", err, 1'b0);
    wv = rvec();
    send_vec(wv, 0);
    exp_w.push_back(wv);
    wv = rvec();
    for (int k = 0; k < 10; k++) send_nib(wv[k*4 +: 4], 0);
    chk("pre_rst_busy", busy, 1'b1);
    rst = 1'b1;
    #1;
    check_zero("midrst");
    tick();
    rst = 1'b0;
    tick();
    check_zero("postrst");
    run_job(rvec(), rvec(), rvec(), 0, 0);

    // start during LOAD_I, s_valid held through DRAIN
    run_job(rvec(), rvec(), rvec(), 0, 1);
    repeat (10) tick();

    chk("w_left", exp_w.size(), 0);
    chk("i_left", exp_i.size(), 0);
    chk("r_left", exp_r.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
